// File: rtl/log2_pow2_pipe.sv
// log2_pow2_pipe: three-stage valid/ready fixed-point log2 / pow2 approximation.
//   op = 0 : log2 of unsigned Q(I).(F) -> signed Q(I).(F)
//            (leading-one position becomes the exponent, the mantissa bits
//            below it become the fraction: a linear mantissa approximation)
//   op = 1 : pow2 of signed Q(I).(F) -> unsigned Q(I).(F)
//            (1.frac shifted by the integer part)
// Optional build macro LOG2POW2_SAT_EN: when defined, out-of-range results
// saturate (pow2 overflow -> all ones, log2 underflow -> most negative).
// When undefined, they wrap (legacy behaviour). out_range_err is identical
// in both builds.
// Parameter limits: W >= 8 and 2 <= I <= W-2, where I = W - F.
module log2_pow2_pipe #(
    parameter int W     = 16,
    parameter int F     = 12,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [W-1:0]     in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic             out_range_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int I       = W - F;
    localparam int PW      = $clog2(W);
    // Wide enough for 1.frac shifted left by the largest positive integer part.
    localparam int PF      = W + 2**(I-1);
    // A leading-one position below this gives an exponent under -2^(I-1).
    localparam int UFLOW_P = F - 2**(I-1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    // Per-stage enables: a stage may load when it is empty or its consumer moves.
    logic en1, en2, en3;

    // Stage 1 registers
    logic             v1_reg, op1_reg;
    logic [W-1:0]     x1_reg;
    logic [TAG_W-1:0] tag1_reg;
    logic [PW-1:0]    p1_reg;

    // Stage 2 registers
    logic             v2_reg, op2_reg;
    logic [TAG_W-1:0] tag2_reg;
    logic             zero2_reg, uflow2_reg, ovf2_reg;
    logic [W-1:0]     log_y2_reg, pow_y2_reg;

    // Stage 3 (output) registers
    logic             v3_reg;
    logic [W-1:0]     y3_reg;
    logic             err3_reg;
    logic [TAG_W-1:0] tag3_reg;

    assign en3      = !v3_reg | out_ready;
    assign en2      = !v2_reg | en3;
    assign en1      = !v1_reg | en2;
    assign in_ready = en1;

    // Leading-one detect on the incoming operand (0 when the operand is zero).
    logic [PW-1:0] lod_p_next;
    always_comb begin
        lod_p_next = '0;
        for (int i = 0; i < W; i++) begin
            if (in_x[i]) lod_p_next = PW'(i);
        end
    end

    // Stage 1: capture the transaction and its leading-one position.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg   <= 1'b0;
            op1_reg  <= 1'b0;
            x1_reg   <= '0;
            tag1_reg <= '0;
            p1_reg   <= '0;
        end else if (en1) begin
            v1_reg <= in_valid;
            if (in_valid) begin
                op1_reg  <= in_op;
                x1_reg   <= in_x;
                tag1_reg <= in_tag;
                p1_reg   <= lod_p_next;
            end
        end
    end

    // Shift stage: normalise the log2 mantissa and scale the pow2 mantissa.
    logic [W-1:0]  norm_m;
    logic [F-1:0]  frac_next;
    logic [I-1:0]  exp_lo_next;
    logic [I-1:0]  k_raw, k_mag;
    logic [PF-1:0] pow_v;
    logic          zero_next, uflow_next, ovf_next;
    always_comb begin
        norm_m      = x1_reg << (PW'(W-1) - p1_reg);
        // Drop the leading one; keep the F bits right below it.
        frac_next   = F'(norm_m >> (W-1-F));
        exp_lo_next = I'(p1_reg) - I'(F);
        zero_next   = ~|x1_reg;
        uflow_next  = int'(p1_reg) < UFLOW_P;

        k_raw = x1_reg[W-1:F];
        k_mag = ~k_raw + I'(1);
        pow_v = PF'({1'b1, x1_reg[F-1:0]});
        if (k_raw[I-1]) begin
            pow_v = pow_v >> k_mag;   // floor; vanishes to 0 for very negative k
        end else begin
            pow_v = pow_v << k_raw;
        end
        // Any bit above the W-bit result means the value reached 2^W.
        ovf_next = |pow_v[PF-1:W];
    end

    // Stage 2: hold both candidate results plus their range flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg     <= 1'b0;
            op2_reg    <= 1'b0;
            tag2_reg   <= '0;
            zero2_reg  <= 1'b0;
            uflow2_reg <= 1'b0;
            ovf2_reg   <= 1'b0;
            log_y2_reg <= '0;
            pow_y2_reg <= '0;
        end else if (en2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                op2_reg    <= op1_reg;
                tag2_reg   <= tag1_reg;
                zero2_reg  <= zero_next;
                uflow2_reg <= uflow_next;
                ovf2_reg   <= ovf_next;
                log_y2_reg <= {exp_lo_next, frac_next};
                pow_y2_reg <= pow_v[W-1:0];
            end
        end
    end

    // Range check and saturate/wrap selection.
    logic [W-1:0] y3_next;
    logic         err3_next;
    always_comb begin
        y3_next   = log_y2_reg;
        err3_next = 1'b0;
        if (op2_reg) begin
            y3_next   = pow_y2_reg;
            err3_next = ovf2_reg;
`ifdef LOG2POW2_SAT_EN
            if (ovf2_reg) y3_next = '1;
`endif
        end else if (zero2_reg) begin
            y3_next   = MOST_NEG;
            err3_next = 1'b1;
        end else if (uflow2_reg) begin
            err3_next = 1'b1;
`ifdef LOG2POW2_SAT_EN
            y3_next   = MOST_NEG;
`endif
        end
    end

    // Stage 3: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_reg   <= 1'b0;
            y3_reg   <= '0;
            err3_reg <= 1'b0;
            tag3_reg <= '0;
        end else if (en3) begin
            v3_reg <= v2_reg;
            if (v2_reg) begin
                y3_reg   <= y3_next;
                err3_reg <= err3_next;
                tag3_reg <= tag2_reg;
            end
        end
    end

    assign out_valid     = v3_reg;
    assign out_y         = y3_reg;
    assign out_range_err = err3_reg;
    assign out_tag       = tag3_reg;

endmodule

// File: tb/tb_log2_pow2_pipe.sv
// Scoreboard bench for log2_pow2_pipe (W=16, F=12, TAG_W=4). Expected results
// are queued when a transaction is accepted and checked in order by a monitor
// when the DUT hands a result downstream.
module tb_log2_pow2_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [15:0] in_x;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic        out_range_err;
    logic [3:0]  out_tag;

    log2_pow2_pipe #(.W(16), .F(12), .TAG_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_x          (in_x),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_y         (out_y),
        .out_range_err (out_range_err),
        .out_tag       (out_tag)
    );

`ifdef LOG2POW2_SAT_EN
    localparam logic [15:0] Y_UFLOW = 16'h8000;
    localparam logic [15:0] Y_OVF   = 16'hFFFF;
`else
    localparam logic [15:0] Y_UFLOW = 16'h5800;
    localparam logic [15:0] Y_OVF   = 16'h0000;
`endif

    typedef struct packed {
        logic [15:0] y;
        logic        err;
        logic [3:0]  tag;
        logic [31:0] acc;
        logic        lat;
    } exp_t;

    typedef struct {
        logic        op;
        logic [15:0] x;
        logic [15:0] y;
        logic        err;
    } vec_t;

    exp_t q[$];
    vec_t vt[9];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pops    = 0;
    int last_acc_cyc = 0;
    int last_pop_cyc = 0;
    int stall_lo = 1;
    int stall_hi = 0;

    logic        acc_now   = 1'b0;
    logic        saw_ir_low = 1'b0;
    logic        drv_lat   = 1'b0;
    logic [15:0] drv_y     = '0;
    logic        drv_err   = 1'b0;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_y     = '0;
    logic        prev_err   = 1'b0;
    logic [3:0]  prev_tag   = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference model: integer arithmetic on the real-valued definitions.
    function automatic logic [16:0] ref_model(input logic op, input logic [15:0] x);
        int          p, e, k;
        longint      v;
        logic [11:0] frac;
        logic [15:0] y;
        logic        err;
        y   = '0;
        err = 1'b0;
        if (!op) begin
            if (x == 16'h0000) begin
                y   = 16'h8000;
                err = 1'b1;
            end else begin
                p = 0;
                while (p < 15 && (int'(x) >> (p + 1)) != 0) p++;
                e    = p - 12;
                frac = 12'((int'(x) << (15 - p)) >> 3);
                y    = {e[3:0], frac};
                if (e < -8) begin
                    err = 1'b1;
`ifdef LOG2POW2_SAT_EN
                    y = 16'h8000;
`endif
                end
            end
        end else begin
            k = int'($signed(x[15:12]));
            v = 64'd4096 + longint'(x[11:0]);
            if (k >= 0) v = v * (longint'(1) << k);
            else        v = v / (longint'(1) << (-k));
            y = 16'(v);
            if (v >= 65536) begin
                err = 1'b1;
`ifdef LOG2POW2_SAT_EN
                y = 16'hFFFF;
`endif
            end
        end
        return {err, y};
    endfunction

    // Monitor / scoreboard: one pass per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        acc_now = 1'b0;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(q.size() == 3 && !out_ready)});
            if (!in_ready) saw_ir_low = 1'b1;
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_y", {16'd0, out_y}, {16'd0, prev_y});
                chk("hold_err", {31'd0, out_range_err}, {31'd0, prev_err});
                chk("hold_tag", {28'd0, out_tag}, {28'd0, prev_tag});
            end
            if (out_valid && q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got y=%h tag=%h expected no output", out_y, out_tag);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                $display("[TB] cyc=%0d tag=%h y=%h err=%b (exp y=%h err=%b)",
                         cyc, out_tag, out_y, out_range_err, e.y, e.err);
                chk("y", {16'd0, out_y}, {16'd0, e.y});
                chk("err", {31'd0, out_range_err}, {31'd0, e.err});
                chk("tag", {28'd0, out_tag}, {28'd0, e.tag});
                if (e.lat) chk("latency", cyc - int'(e.acc), 32'd3);
                pops++;
                last_pop_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            prev_err   = out_range_err;
            prev_tag   = out_tag;
            if (in_valid && in_ready) begin
                q.push_back('{y: drv_y, err: drv_err, tag: in_tag, acc: cyc, lat: drv_lat});
                acc_now      = 1'b1;
                last_acc_cyc = cyc;
            end
        end
    end

    // Downstream ready, low inside the configured stall window.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
        end
    end

    task automatic send(input logic op, input logic [15:0] x, input logic [3:0] tag,
                        input logic [15:0] ey, input logic eerr, input logic lat);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = op;
        in_x     = x;
        in_tag   = tag;
        drv_y    = ey;
        drv_err  = eerr;
        drv_lat  = lat;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!acc_now && n < 100);
        if (!acc_now) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of tag %h", tag);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, p0;
        logic [16:0] r;
        logic        rop;
        logic [15:0] rx;

        vt[0] = '{1'b0, 16'h1000, 16'h0000, 1'b0};
        vt[1] = '{1'b0, 16'h8000, 16'h3000, 1'b0};
        vt[2] = '{1'b0, 16'h3000, 16'h1800, 1'b0};
        vt[3] = '{1'b1, 16'h1800, 16'h3000, 1'b0};
        vt[4] = '{1'b1, 16'hF000, 16'h0800, 1'b0};
        vt[5] = '{1'b1, 16'h8000, 16'h0010, 1'b0};
        vt[6] = '{1'b0, 16'h0000, 16'h8000, 1'b1};
        vt[7] = '{1'b0, 16'h0003, Y_UFLOW,  1'b1};
        vt[8] = '{1'b1, 16'h4000, Y_OVF,    1'b1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 1'b0;
        in_x     = '0;
        in_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y", {16'd0, out_y}, 32'd0);
        chk("rst_out_err", {31'd0, out_range_err}, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed log2 / pow2 / range vectors, back to back, exact latency
        for (int i = 0; i < 9; i++)
            send(vt[i].op, vt[i].x, 4'(i), vt[i].y, vt[i].err, 1'b1);
        idle();
        drain();

        // Backpressure: 8 tagged mixed ops, downstream stalled mid-stream
        saw_ir_low = 1'b0;
        p0 = pops;
        stall_lo = cyc + 5;
        stall_hi = cyc + 10;
        for (int i = 0; i < 8; i++)
            send(vt[i].op, vt[i].x, 4'(i + 5), vt[i].y, vt[i].err, 1'b0);
        idle();
        drain();
        chk("bp_in_ready_fell", {31'd0, saw_ir_low}, 32'd1);
        chk("bp_result_count", pops - p0, 32'd8);

        // Full throughput: 100 random ops, downstream always ready
        for (int i = 0; i < 100; i++) begin
            rop = 1'($urandom_range(0, 1));
            rx  = 16'($urandom_range(0, 65535));
            r   = ref_model(rop, rx);
            send(rop, rx, 4'(i), r[15:0], r[16], 1'b1);
            if (i == 0) c0 = last_acc_cyc;
        end
        idle();
        drain();
        chk("throughput_cycles", last_pop_cyc - c0 + 1, 32'd103);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++)
            send(vt[i + 3].op, vt[i + 3].x, 4'hA, vt[i + 3].y, vt[i + 3].err, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        send(vt[2].op, vt[2].x, 4'h3, vt[2].y, vt[2].err, 1'b1);
        idle();
        drain();
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/log2_pow2_pipe.md
# log2_pow2_pipe

Pipelined, parametrised fixed-point log2/pow2 approximation unit. Each transaction selects one operation: log2 (leading-one detect plus linear mantissa) or pow2 (1.frac shifted by the integer part). The unit has a 3-stage valid/ready pipeline, full throughput, and a sideband tag. It sits in the exponential/softmax datapath, between the max-subtract stage and the accumulator.

## Interface
- `W`, 16, total data width; must be ≥ 8.
- `F`, 12, fraction bits; `I = W - F` integer bits; must satisfy 2 ≤ I ≤ W-2.
- `TAG_W`, 4, sideband tag width; tag is passed through unchanged.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input transaction valid.
- `in_ready`  out  1  unit accepts the input this cycle.
- `in_op`  in  1  operation select: 0 = log2, 1 = pow2.
- `in_x`  in  W  operand. For log2: unsigned Q(I).(F). For pow2: signed Q(I).(F).
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_y`  out  W  result. For log2: signed Q(I).(F). For pow2: unsigned Q(I).(F).
- `out_range_err`  out  1  result is out of range (see Operation).
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- **Stage 1 (S1):** register `op`, `x`, `tag`.
  - log2: leading-one position `p` (0..W-1).
  - pow2: integer part `k = x[W-1:F]` (signed).
- **Stage 2 (S2):** shift.
  - log2: `m = x << (W-1-p)`; `frac = m[W-2 : W-1-F]`; `e = p - F` (I+2-bit signed).
  - pow2: `v = {1, x[F-1:0]}`. If `k ≥ 0`, `v << k` in a W+2^(I-1)-bit field; otherwise `v >> -k` (logical, floor).
- **Stage 3 (S3):** range check, saturate or wrap, then drive the outputs.
- **log2 normal case:** `out_y = {e[I-1:0], frac}`.
- **log2 zero input:** `out_y` = most negative value (`1` followed by W-1 zeros), `out_range_err = 1`. This holds with or without the macro.
- **log2 underflow** (`e < -2^(I-1)`): `out_range_err = 1`; the value is set by the macro.
- **pow2 overflow** (`k > I-1`, result ≥ 2^W): `out_range_err = 1`; the value is set by the macro.
- **pow2 small results** (`k ≤ -(F+1)`): result is 0, `out_range_err = 0`.
- **Flow control:** stall-per-stage, bubble-collapsing.
  - `en3 = !v3 | out_ready`
  - `en2 = !v2 | en3`
  - `en1 = !v1 | en2`
  - `in_ready = en1`
  - Stage n loads when `en_n`; its valid takes the upstream valid.
- Data, tag, and op stay together in each stage. Outputs hold stable while `out_valid & !out_ready`.

## Timing
- Latency: 3 cycles from the accept edge (`in_valid & in_ready`) to `out_valid`.
- Throughput: 1 transaction per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_ready` through the valid chain. No other combinational input-to-output path exists.
- Full pipeline with `out_ready = 0`: `in_ready = 0`. On the cycle `out_ready` rises, `in_ready = 1` and a new input is accepted in the same cycle.
- Simultaneous accept and drain in one cycle: both take effect; occupancy is unchanged.
- Reset: `rst = 1` at an edge clears `v1`, `v2`, `v3`.
  - `out_valid = 0`, `out_y = 0`, `out_range_err = 0`, `out_tag = 0`.
  - `in_ready = 1` in the cycle after reset.
  - In-flight transactions are discarded.
- Mixed ops back-to-back carry no penalty.

## Configuration
- Macro: `LOG2POW2_SAT_EN`.
- **Defined:**
  - pow2 overflow gives `out_y` = all ones.
  - log2 underflow gives `out_y` = most negative value.
- **Undefined (legacy wrap):**
  - pow2 overflow gives the low W bits of the shifted value.
  - log2 underflow gives `{e[I-1:0], frac}`, i.e. the exponent wraps.
- `out_range_err` behaves identically in both builds.

## Test plan
All values use defaults (W=16, F=12).
1. log2 directed values:
   - `0x1000` → `0x0000`
   - `0x8000` → `0x3000`
   - `0x3000` → `0x1800`
   - All with `err = 0`, `out_valid` exactly 3 cycles after accept.
2. pow2 directed values:
   - `0x1800` → `0x3000`
   - `0xF000` → `0x0800`
   - `0x8000` (`k = -8`) → `0x0010`
   - All with `err = 0`.
3. Range cases:
   - log2 `0x0000` → `0x8000`, `err = 1`.
   - log2 `0x0003`: SAT build → `0x8000`; wrap build → `0x5800`. `err = 1` in both.
   - pow2 `0x4000`: SAT build → `0xFFFF`; wrap build → `0x0000`. `err = 1` in both.
4. Backpressure:
   - Stream 8 tagged mixed ops; hold `out_ready = 0` for cycles 4–9.
   - `in_ready` falls after 3 accepts.
   - Outputs hold stable while stalled.
   - All 8 results arrive in order with matching tags, none dropped or duplicated.
5. Full throughput: 100 random ops with `out_ready = 1` complete in 103 cycles, and every result matches the reference model.
6. Reset mid-stream: assert `rst` with 3 transactions in flight.
   - Next cycle: `out_valid = 0`, `in_ready = 1`.
   - A subsequent single op returns after 3 cycles with no stale outputs.
